// File: rtl/core_mem_bridge.sv
// Bus responder for the 8088 core: serves byte cycles from a 512K x 16
// async SRAM with programmable wait states and a one-word read buffer.
module core_mem_bridge #(
    parameter int WAIT_STATES = 2,
    parameter bit BUF_EN      = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] address,
    input  logic [7:0]  out,
    input  logic        we,
    output logic [7:0]  in,
    output logic        locked,
    output logic [18:0] sram_a,
    input  logic [15:0] sram_di,
    output logic [15:0] sram_do,
    output logic        sram_dq_oe,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_CNT = 4'(WAIT_STATES - 1);

    state_t      r_state;
    state_t      w_nxt;
    logic [19:0] r_addr;
    logic        r_we;
    logic [7:0]  r_dat;
    logic [3:0]  r_cnt;
    logic [15:0] r_buf;
    logic [18:0] r_tag;
    logic        r_vld;
    logic        w_hit;
    logic        w_tag_eq;

    assign w_hit = !we && BUF_EN && r_vld &&
                   (address[19:1] == r_tag);
    assign w_tag_eq = r_vld && (r_addr[19:1] == r_tag);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_ISSUE;
        else       r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_ISSUE: w_nxt = w_hit ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_nxt = S_DONE;
            S_DONE:  w_nxt = S_ISSUE;
            default: w_nxt = S_ISSUE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_dat      <= '0;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_tag      <= '0;
            r_vld      <= 1'b0;
            in         <= '0;
            locked     <= 1'b0;
            sram_a     <= '0;
            sram_do    <= '0;
            sram_dq_oe <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    r_addr <= address;
                    r_we   <= we;
                    r_dat  <= out;
                    if (w_hit) begin
                        in     <= address[0] ? r_buf[15:8] : r_buf[7:0];
                        locked <= 1'b1;
                    end else begin
                        sram_a <= address[19:1];
                        r_cnt  <= LP_CNT;
                        if (we) begin
                            sram_do    <= {out, out};
                            sram_dq_oe <= 1'b1;
                            sram_we_n  <= 1'b0;
                            sram_lb_n  <= address[0];
                            sram_ub_n  <= ~address[0];
                        end else begin
                            sram_oe_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                        // release WE one cycle early for hold time
                        if (r_cnt == 4'd1) sram_we_n <= 1'b1;
                    end else begin
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_lb_n  <= 1'b1;
                        sram_ub_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        locked     <= 1'b1;
                        if (!r_we) begin
                            in    <= r_addr[0] ? sram_di[15:8] : sram_di[7:0];
                            r_buf <= sram_di;
                            r_tag <= r_addr[19:1];
                            r_vld <= BUF_EN;
                        end else if (w_tag_eq) begin
                            if (r_addr[0]) r_buf[15:8] <= r_dat;
                            else           r_buf[7:0]  <= r_dat;
                        end
                    end
                end
                S_DONE: locked <= 1'b0;
                default: locked <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: buffered WS=2 instance plus
// an unbuffered WS=1 instance, both backed by a behavioural SRAM.
module tb_core_mem_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [19:0] address;
    logic [7:0]  out;
    logic        we;
    logic [7:0]  in;
    logic        locked;
    logic [18:0] sram_a;
    logic [15:0] sram_di;
    logic [15:0] sram_do;
    logic        sram_dq_oe;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    logic        reset2;
    logic [19:0] address2;
    logic [7:0]  in2;
    logic        locked2;
    logic [18:0] sram2_a;
    logic [15:0] sram2_di;
    logic [15:0] sram2_do;
    logic        sram2_dq_oe;
    logic        sram2_oe_n;
    logic        sram2_we_n;
    logic        sram2_lb_n;
    logic        sram2_ub_n;

    logic [15:0] mem [0:524287];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc;
    int          oe_cnt;
    int          we_cnt;
    logic [18:0] cap_a;
    logic [15:0] cap_do;
    logic        cap_lb;
    logic        cap_ub;
    logic        cap_dq;
    logic [7:0]  rd;

    always #5 clock = ~clock;

    core_mem_bridge #(.WAIT_STATES(2), .BUF_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .address(address),
        .out(out), .we(we), .in(in), .locked(locked),
        .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do),
        .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n),
        .sram_ub_n(sram_ub_n)
    );

    core_mem_bridge #(.WAIT_STATES(1), .BUF_EN(1'b0)) dut2 (
        .clock(clock), .reset(reset2), .address(address2),
        .out(8'h00), .we(1'b0), .in(in2), .locked(locked2),
        .sram_a(sram2_a), .sram_di(sram2_di), .sram_do(sram2_do),
        .sram_dq_oe(sram2_dq_oe), .sram_oe_n(sram2_oe_n),
        .sram_we_n(sram2_we_n), .sram_lb_n(sram2_lb_n),
        .sram_ub_n(sram2_ub_n)
    );

    assign sram_di  = !sram_oe_n  ? mem[sram_a]  : 16'h0000;
    assign sram2_di = !sram2_oe_n ? mem[sram2_a] : 16'h0000;

    always @(posedge clock) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_a][7:0]  <= sram_do[7:0];
            if (!sram_ub_n) mem[sram_a][15:8] <= sram_do[15:8];
        end
    end

    task automatic run(input logic [19:0] a, input logic w,
                       input logic [7:0] d);
        bit done = 0;
        address = a;
        we = w;
        out = d;
        cyc = 0;
        oe_cnt = 0;
        we_cnt = 0;
        cap_a = '0;
        cap_do = '0;
        cap_lb = 1'b1;
        cap_ub = 1'b1;
        cap_dq = 1'b0;
        rd = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) begin
                we_cnt++;
                cap_a = sram_a;
                cap_do = sram_do;
                cap_lb = sram_lb_n;
                cap_ub = sram_ub_n;
                cap_dq = sram_dq_oe;
            end
            if (locked) begin
                done = 1;
                cyc = k + 2;
                rd = in;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout addr=%h locked never rose", a);
        end else begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic run2(input logic [19:0] a);
        bit done = 0;
        address2 = a;
        cyc = 0;
        oe_cnt = 0;
        rd = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (!sram2_oe_n) oe_cnt++;
            if (locked2) begin
                done = 1;
                cyc = k + 2;
                rd = in2;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout2 addr=%h locked never rose", a);
        end else begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset2 = 1'b1;
        address = '0;
        address2 = '0;
        we = 1'b0;
        out = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_chk++;
        if (locked !== 1'b0 || in !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_core locked=%b in=%h need 0/00", locked, in);
        end
        n_chk++;
        if ({sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_strobe got=%b need 1111",
                     {sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
        end
        n_chk++;
        if (sram_dq_oe !== 1'b0 || sram_a !== '0 || sram_do !== '0) begin
            n_fail++;
            $display("FAIL rst_bus oe=%b a=%h do=%h need 0/0/0",
                     sram_dq_oe, sram_a, sram_do);
        end
        reset = 1'b0;
    endtask

    task automatic test_read_miss();
        run(20'hFFFF0, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'hEF) begin
            n_fail++;
            $display("FAIL miss_data got=%h need EF", rd);
        end
        n_chk++;
        if (cyc !== 4 || oe_cnt !== 2) begin
            n_fail++;
            $display("FAIL miss_timing cyc=%0d oe=%0d need 4/2", cyc, oe_cnt);
        end
        n_chk++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL locked_pulse got=%b need 0", locked);
        end
    endtask

    task automatic test_read_hit();
        run(20'hFFFF1, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'hBE) begin
            n_fail++;
            $display("FAIL hit_data got=%h need BE", rd);
        end
        n_chk++;
        if (cyc !== 2 || oe_cnt !== 0) begin
            n_fail++;
            $display("FAIL hit_timing cyc=%0d oe=%0d need 2/0", cyc, oe_cnt);
        end
    endtask

    task automatic test_write();
        run(20'h00101, 1'b1, 8'h5A);
        n_chk++;
        if (cap_a !== 19'h00080 || cap_do !== 16'h5A5A || cap_dq !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_bus a=%h do=%h dq=%b need 00080/5A5A/1",
                     cap_a, cap_do, cap_dq);
        end
        n_chk++;
        if (cap_ub !== 1'b0 || cap_lb !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_lane ub=%b lb=%b need 0/1", cap_ub, cap_lb);
        end
        n_chk++;
        if (we_cnt !== 1 || cyc !== 4) begin
            n_fail++;
            $display("FAIL wr_timing we=%0d cyc=%0d need 1/4", we_cnt, cyc);
        end
        run(20'h00101, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'h5A || cyc !== 4) begin
            n_fail++;
            $display("FAIL wr_readback got=%h cyc=%0d need 5A/4", rd, cyc);
        end
    endtask

    task automatic test_write_through();
        run(20'h00200, 1'b0, 8'h00);
        mem[19'h00080] = 16'h1234;
        run(20'h00101, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'h12 || cyc !== 4) begin
            n_fail++;
            $display("FAIL wt_fill got=%h cyc=%0d need 12/4", rd, cyc);
        end
        run(20'h00100, 1'b1, 8'hCC);
        n_chk++;
        if (cap_lb !== 1'b0 || cap_ub !== 1'b1 || cyc !== 4) begin
            n_fail++;
            $display("FAIL wt_write lb=%b ub=%b cyc=%0d need 0/1/4",
                     cap_lb, cap_ub, cyc);
        end
        run(20'h00100, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'hCC || cyc !== 2) begin
            n_fail++;
            $display("FAIL wt_hit_lo got=%h cyc=%0d need CC/2", rd, cyc);
        end
        run(20'h00101, 1'b0, 8'h00);
        n_chk++;
        if (rd !== 8'h12 || cyc !== 2) begin
            n_fail++;
            $display("FAIL wt_hit_hi got=%h cyc=%0d need 12/2", rd, cyc);
        end
    endtask

    task automatic test_reset_mid_write();
        address = 20'h00300;
        we = 1'b1;
        out = 8'h77;
        @(posedge clock);
        @(negedge clock);
        n_chk++;
        if (sram_we_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_we got=%b need 0", sram_we_n);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_chk++;
        if (sram_we_n !== 1'b1 || locked !== 1'b0 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort we_n=%b locked=%b dq=%b need 1/0/0",
                     sram_we_n, locked, sram_dq_oe);
        end
        @(negedge clock);
        reset = 1'b0;
        run(20'h00101, 1'b0, 8'h00);
        n_chk++;
        if (cyc !== 4 || oe_cnt !== 2 || rd !== 8'h12) begin
            n_fail++;
            $display("FAIL mid_miss cyc=%0d oe=%0d rd=%h need 4/2/12",
                     cyc, oe_cnt, rd);
        end
    endtask

    task automatic test_no_buffer();
        address2 = 20'h00101;
        @(negedge clock);
        reset2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run2(20'h00101);
            n_chk++;
            if (cyc !== 3 || oe_cnt !== 1 || rd !== 8'h12) begin
                n_fail++;
                $display("FAIL nobuf_%0d cyc=%0d oe=%0d rd=%h need 3/1/12",
                         i, cyc, oe_cnt, rd);
            end
        end
    endtask

    initial begin
        mem[19'h7FFF8] = 16'hBEEF;
        mem[19'h00080] = 16'h0034;
        mem[19'h00100] = 16'h0000;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_write_through();
        test_reset_mid_write();
        test_no_buffer();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
